cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Write-back arbiter for the out-of-order core's common data bus (CDB). It sits between the functional units (ALU, load/store, branch) that produce results and the two result-broadcast ports that every reservation station, the register file and the ROB snoop. Up to `NUM_SRC` producers compete for the two ports. Each cycle the block grants at most two of them, round-robin, and drives registered broadcasts one cycle later.

## Interface
Parameters:
- `NUM_SRC`, 3: number of result producers; index 0 = ALU, 1 = LS, 2 = BR.
- `TAG_W`, 4: tag width; equals the shared tag bus width.
- `DATA_W`, 32: result data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_valid`  in  `NUM_SRC`  producer i holds a result.
- `src_tag`  in  `NUM_SRC*TAG_W`  flattened tags; slice i = `[i*TAG_W +: TAG_W]`.
- `src_data`  in  `NUM_SRC*DATA_W`  flattened result data, same slicing.
- `src_ready`  out  `NUM_SRC`  combinational grant; result i is accepted at this posedge.
- `wrt_en_o`, `wrt_tag_o`, `wrt_data_o`  out  1 / `TAG_W` / `DATA_W`  broadcast port O (first grant).
- `wrt_en_t`, `wrt_tag_t`, `wrt_data_t`  out  1 / `TAG_W` / `DATA_W`  broadcast port T (second grant).

## Operation
- State:
  - round-robin pointer `rr_ptr`, range 0..NUM_SRC-1.
  - registered output ports O and T.
- Search order each cycle: `rr_ptr`, `rr_ptr+1`, … modulo `NUM_SRC`.
  - First valid source found → port O.
  - Second valid source found → port T.
  - `src_ready` is high for exactly those granted sources; at most two bits are set.
- Pointer update:
  - If at least one grant: `rr_ptr` ← (index of last granted source + 1) mod `NUM_SRC`.
  - If no grant: `rr_ptr` unchanged.
- Output update:
  - A granted port loads en=1 with the granted source's tag and data.
  - An ungranted port loads en=0, tag=`TAG_FREE`, data=0.
  - Both ports therefore return to idle one cycle after a broadcast unless they are re-granted.
- Producer handshake:
  - A producer holds `src_valid`, tag and data stable until it sees `src_ready` high at a posedge.
  - Dropping valid before acceptance is a protocol violation; the bench asserts on it.
  - The same tag is never broadcast twice for a single valid period.
- Reset values: `wrt_en_o`/`wrt_en_t` = 0, tags = `TAG_FREE`, data = 0, `rr_ptr` = 0.
- Reset mid-operation:
  - Outputs clear immediately, with no clock edge needed.
  - A grant made in the cycle reset asserts is lost.
  - Producers keep valid asserted and are re-arbitrated after reset deasserts.
- A valid source carrying tag == `TAG_FREE` is forwarded unchanged; flagging it is the producer's fault and the bench's job.

## Timing
- Grant at posedge N (`src_ready` high during cycle N-1→N). Broadcast is visible during cycle N→N+1. Latency is 1 cycle.
- Throughput: 2 results per cycle sustained.
- `src_ready` is combinational from `src_valid` and `rr_ptr`. There is no combinational path from `src_ready` back to `src_valid` inside the block.
- Simultaneous events: the O and T grants never select the same source.

## Configuration
- `CDB_RR_EN` defined:
  - round-robin order as above.
  - `rr_ptr` register present.
- `CDB_RR_EN` undefined:
  - fixed priority; search order is always 0,1,…,NUM_SRC-1, so the ALU has the highest priority.
  - no pointer register.
  - starvation of higher indices is possible and accepted.

## Structure
- Shared package: `TAG_FREE`, `DATA_FREE` (0), tag/data widths, source index constants (ALU=0, LS=1, BR=2).
- Sub-module `rr_pick2`: given the valid vector and start pointer, returns two one-hot grants plus their indices and valid bits. It is purely combinational and instantiated once.
- Top level holds the pointer, output registers and the data muxes.

## Test plan
- Reset asserted asynchronously while `wrt_en_o`=1 with tag 5 → outputs go to en 0 / `TAG_FREE` / 0 before the next edge; `rr_ptr`=0.
- Only src0 valid, tag 3, data 0x11 → `src_ready`=3'b001. Next cycle: `wrt_en_o`=1, tag 3, data 0x11; `wrt_en_t`=0.
- src0 and src2 valid, `rr_ptr`=0 → `src_ready`=3'b101; port O=src0, port T=src2; `rr_ptr`→0.
- All three valid, `rr_ptr`=0:
  - cycle 1 grants 0,1; `rr_ptr`→2.
  - cycle 2 grants 2,0 (O=src2, T=src0); `rr_ptr`→1.
- src0/src1 valid every cycle, src2 valid once:
  - with `CDB_RR_EN`, src2 is granted within 2 cycles.
  - without it, src2 is never granted while 0/1 stay valid.
- Producer drops valid in the cycle before its grant → bench protocol assertion fires; no broadcast of that tag.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB write-back arbiter: idle tag/data values,
// default widths and producer index assignments.
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    localparam logic [CDB_TAG_W-1:0]  TAG_FREE  = '1;
    localparam logic [CDB_DATA_W-1:0] DATA_FREE = '0;

    typedef enum int {
        SRC_ALU = 0,
        SRC_LS  = 1,
        SRC_BR  = 2
    } src_idx_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational two-winner picker: scans the valid vector starting at a
// pointer and returns the first and second hits as one-hot grants plus indices.
module cdb_arbiter_rr_pick2 #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     gnt_o,
    output logic [N-1:0]     gnt_t,
    output logic [PTR_W-1:0] idx_o,
    output logic [PTR_W-1:0] idx_t,
    output logic             vld_o,
    output logic             vld_t
);

    int cand;

    always_comb begin
        gnt_o = '0;
        gnt_t = '0;
        idx_o = '0;
        idx_t = '0;
        vld_o = 1'b0;
        vld_t = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            // start is always < N, so one conditional subtract wraps the scan
            cand = (int'(start) + k >= N) ? int'(start) + k - N : int'(start) + k;
            if (valid[cand]) begin
                if (!vld_o) begin
                    vld_o       = 1'b1;
                    idx_o       = PTR_W'(cand);
                    gnt_o[cand] = 1'b1;
                end else if (!vld_t) begin
                    vld_t       = 1'b1;
                    idx_t       = PTR_W'(cand);
                    gnt_t[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB write-back arbiter: grants up to two producers per cycle onto registered
// broadcast ports O and T. Define CDB_RR_EN for round-robin, else fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      wrt_en_o,
    output logic [TAG_W-1:0]          wrt_tag_o,
    output logic [DATA_W-1:0]         wrt_data_o,
    output logic                      wrt_en_t,
    output logic [TAG_W-1:0]          wrt_tag_t,
    output logic [DATA_W-1:0]         wrt_data_t
);

    localparam int PTR_W = ptr_width(NUM_SRC);
    localparam logic [TAG_W-1:0]  TAG_IDLE  = TAG_W'(TAG_FREE);
    localparam logic [DATA_W-1:0] DATA_IDLE = DATA_W'(DATA_FREE);

    logic [PTR_W-1:0]   start;
    logic [PTR_W-1:0]   idx_o;
    logic [PTR_W-1:0]   idx_t;
    logic               vld_o;
    logic               vld_t;
    logic [NUM_SRC-1:0] gnt_o;
    logic [NUM_SRC-1:0] gnt_t;
    logic [TAG_W-1:0]   sel_tag_o;
    logic [TAG_W-1:0]   sel_tag_t;
    logic [DATA_W-1:0]  sel_data_o;
    logic [DATA_W-1:0]  sel_data_t;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] last_idx;

    assign last_idx = vld_t ? idx_t : idx_o;

    // Pointer moves past the last winner so it loses priority next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= PTR_W'(SRC_ALU);
        end else if (vld_o) begin
            rr_ptr <= (int'(last_idx) == NUM_SRC - 1) ? '0 : last_idx + PTR_W'(1);
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    cdb_arbiter_rr_pick2 #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick2 (
        .valid (src_valid),
        .start (start),
        .gnt_o (gnt_o),
        .gnt_t (gnt_t),
        .idx_o (idx_o),
        .idx_t (idx_t),
        .vld_o (vld_o),
        .vld_t (vld_t)
    );

    assign src_ready  = gnt_o | gnt_t;

    assign sel_tag_o  = src_tag[int'(idx_o)*TAG_W +: TAG_W];
    assign sel_tag_t  = src_tag[int'(idx_t)*TAG_W +: TAG_W];
    assign sel_data_o = src_data[int'(idx_o)*DATA_W +: DATA_W];
    assign sel_data_t = src_data[int'(idx_t)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt_en_o   <= 1'b0;
            wrt_tag_o  <= TAG_IDLE;
            wrt_data_o <= DATA_IDLE;
            wrt_en_t   <= 1'b0;
            wrt_tag_t  <= TAG_IDLE;
            wrt_data_t <= DATA_IDLE;
        end else begin
            wrt_en_o   <= vld_o;
            wrt_tag_o  <= vld_o ? sel_tag_o  : TAG_IDLE;
            wrt_data_o <= vld_o ? sel_data_o : DATA_IDLE;
            wrt_en_t   <= vld_t;
            wrt_tag_t  <= vld_t ? sel_tag_t  : TAG_IDLE;
            wrt_data_t <= vld_t ? sel_data_t : DATA_IDLE;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter; follows CDB_RR_EN to pick the
// round-robin or fixed-priority reference ordering.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic          en_o;
        logic [TW-1:0] tag_o;
        logic [DW-1:0] data_o;
        logic          en_t;
        logic [TW-1:0] tag_t;
        logic [DW-1:0] data_t;
    } bc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*TW-1:0] src_tag   = '0;
    logic [N*DW-1:0] src_data  = '0;
    logic [N-1:0]  src_ready;
    logic          wrt_en_o, wrt_en_t;
    logic [TW-1:0] wrt_tag_o, wrt_tag_t;
    logic [DW-1:0] wrt_data_o, wrt_data_t;

    bc_t           sb[$];
    logic [TW-1:0] t[N];
    logic [DW-1:0] d[N];
    int            m_ptr = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            viol  = 0;
    logic [N-1:0]  pend  = '0;

    logic [N-1:0]  ro, re;
    bc_t           bo, be;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_tag    (src_tag),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .wrt_en_o   (wrt_en_o),
        .wrt_tag_o  (wrt_tag_o),
        .wrt_data_o (wrt_data_o),
        .wrt_en_t   (wrt_en_t),
        .wrt_tag_t  (wrt_tag_t),
        .wrt_data_t (wrt_data_t)
    );

    // Producer-side protocol monitor: a pending result must stay valid until granted.
    always @(posedge clk) begin
        if (rst) begin
            pend = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (pend[i] && !src_valid[i]) viol++;
            pend = src_valid & ~src_ready;
        end
    end

    function automatic void pick(input logic [N-1:0] v, input int ptr,
                                 output logic [N-1:0] g, output int io, output int it,
                                 output bit vo, output bit vt);
        g = '0; io = 0; it = 0; vo = 0; vt = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j]) begin
                if (!vo) begin
                    vo = 1; io = j; g[j] = 1'b1;
                end else if (!vt) begin
                    vt = 1; it = j; g[j] = 1'b1;
                end
            end
        end
    endfunction

    task automatic apply(input logic [N-1:0] v, output logic [N-1:0] r_obs,
                         output logic [N-1:0] r_exp, output bc_t b_obs, output bc_t b_exp);
        logic [N-1:0] g;
        int io, it;
        bit vo, vt;
        bc_t e;
        @(negedge clk);
        src_valid = v;
        for (int i = 0; i < N; i++) begin
            src_tag[i*TW +: TW]  = t[i];
            src_data[i*DW +: DW] = d[i];
        end
        #1;
        r_obs = src_ready;
        pick(v, m_ptr, g, io, it, vo, vt);
        r_exp    = g;
        e.en_o   = vo;
        e.tag_o  = vo ? t[io] : TAG_FREE;
        e.data_o = vo ? d[io] : '0;
        e.en_t   = vt;
        e.tag_t  = vt ? t[it] : TAG_FREE;
        e.data_t = vt ? d[it] : '0;
        sb.push_back(e);
`ifdef CDB_RR_EN
        if (vo) m_ptr = ((vt ? it : io) + 1) % N;
`endif
        @(posedge clk);
        #1;
        b_obs = {wrt_en_o, wrt_tag_o, wrt_data_o, wrt_en_t, wrt_tag_t, wrt_data_t};
        b_exp = sb.pop_front();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        src_valid = '0;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({wrt_en_o, wrt_en_t} !== 2'b00 || wrt_tag_o !== TAG_FREE || wrt_tag_t !== TAG_FREE ||
            wrt_data_o !== '0 || wrt_data_t !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got en %b%b tags %h/%h data %h/%h want 00 %h/%h 0/0",
                     wrt_en_o, wrt_en_t, wrt_tag_o, wrt_tag_t, wrt_data_o, wrt_data_t, TAG_FREE, TAG_FREE);
        end
        n_vec++;
        if (src_ready !== 3'b000) begin
            n_err++; $display("FAIL reset_ready got %b want 000", src_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        t[0] = 4'd3; d[0] = 32'h11;
        apply(3'b001, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b001) begin n_err++; $display("FAIL single_ready got %b want 001", ro); end
        n_vec++;
        if (bo !== be) begin n_err++; $display("FAIL single_bcast got %h want %h", bo, be); end
        n_vec++;
        if (bo.en_o !== 1'b1 || bo.tag_o !== 4'd3 || bo.data_o !== 32'h11 || bo.en_t !== 1'b0) begin
            n_err++; $display("FAIL single_fields got %h want en_o 1 tag 3 data 11 en_t 0", bo);
        end
        apply(3'b000, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b000 || bo !== be) begin
            n_err++; $display("FAIL single_idle got %b/%h want 000/%h", ro, bo, be);
        end
    endtask

    task automatic test_pair();
        do_reset();
        t[0] = 4'h2; d[0] = 32'hA0;
        t[2] = 4'h7; d[2] = 32'hC2;
        apply(3'b101, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b101) begin n_err++; $display("FAIL pair_ready got %b want 101", ro); end
        n_vec++;
        if (bo.tag_o !== 4'h2 || bo.tag_t !== 4'h7 || bo !== be) begin
            n_err++; $display("FAIL pair_bcast got %h want %h", bo, be);
        end
        apply(3'b000, ro, re, bo, be);
    endtask

    task automatic test_all_three();
        do_reset();
        t[0] = 4'h1; d[0] = 32'h100;
        t[1] = 4'h4; d[1] = 32'h104;
        t[2] = 4'h9; d[2] = 32'h109;
        apply(3'b111, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b011 || bo !== be) begin
            n_err++; $display("FAIL all3_c1 got %b/%h want 011/%h", ro, bo, be);
        end
        t[0] = 4'h2; d[0] = 32'h200;
        t[1] = 4'h5; d[1] = 32'h205;
        apply(3'b111, ro, re, bo, be);
        n_vec++;
        if (ro !== re || bo !== be) begin
            n_err++; $display("FAIL all3_c2 got %b/%h want %b/%h", ro, bo, re, be);
        end
`ifdef CDB_RR_EN
        n_vec++;
        if (ro !== 3'b101 || bo.tag_o !== 4'h9 || bo.tag_t !== 4'h2) begin
            n_err++; $display("FAIL all3_rr_order got %b O=%h T=%h want 101 O=9 T=2", ro, bo.tag_o, bo.tag_t);
        end
`else
        n_vec++;
        if (ro !== 3'b011 || bo.tag_o !== 4'h2 || bo.tag_t !== 4'h5) begin
            n_err++; $display("FAIL all3_fixed_order got %b O=%h T=%h want 011 O=2 T=5", ro, bo.tag_o, bo.tag_t);
        end
`endif
    endtask

    task automatic test_starvation();
        logic [N-1:0] v;
        int g2;
        do_reset();
        v = 3'b111; g2 = -1;
        t[2] = 4'hB; d[2] = 32'hB0B0;
        for (int c = 0; c < 6; c++) begin
            if (re[0] || c == 0) begin t[0] = TW'(c); d[0] = 32'h1000 + c; end
            if (re[1] || c == 0) begin t[1] = TW'(c + 6); d[1] = 32'h2000 + c; end
            apply(v, ro, re, bo, be);
            n_vec++;
            if (ro !== re || bo !== be) begin
                n_err++; $display("FAIL starve_c%0d got %b/%h want %b/%h", c, ro, bo, re, be);
            end
            if (ro[2] && g2 < 0) g2 = c;
            if (re[2]) v[2] = 1'b0;
        end
`ifdef CDB_RR_EN
        n_vec++;
        if (g2 < 0 || g2 > 1) begin n_err++; $display("FAIL starve_rr_grant got cycle %0d want <=1", g2); end
`else
        n_vec++;
        if (g2 != -1) begin n_err++; $display("FAIL starve_fixed got src2 grant cycle %0d want none", g2); end
        apply(3'b100, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b100 || bo.tag_o !== 4'hB || bo !== be) begin
            n_err++; $display("FAIL starve_drain got %b/%h want 100/%h", ro, bo, be);
        end
`endif
    endtask

    task automatic test_tag_free();
        do_reset();
        t[1] = TAG_FREE; d[1] = 32'hDEAD;
        apply(3'b010, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b010 || bo.en_o !== 1'b1 || bo.tag_o !== TAG_FREE || bo.data_o !== 32'hDEAD || bo !== be) begin
            n_err++; $display("FAIL tag_free_fwd got %b/%h want 010/%h", ro, bo, be);
        end
        apply(3'b000, ro, re, bo, be);
    endtask

    task automatic test_reset_mid();
        do_reset();
        t[0] = 4'd5; d[0] = 32'h55;
        apply(3'b001, ro, re, bo, be);
        n_vec++;
        if (bo.en_o !== 1'b1 || bo.tag_o !== 4'd5 || bo !== be) begin
            n_err++; $display("FAIL rstmid_pre got %h want %h", bo, be);
        end
        t[0] = 4'd6; d[0] = 32'h66;
        src_tag[0 +: TW]  = t[0];
        src_data[0 +: DW] = d[0];
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (wrt_en_o !== 1'b0 || wrt_tag_o !== TAG_FREE || wrt_data_o !== '0 || wrt_en_t !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async got en %b tag %h data %h want 0 %h 0", wrt_en_o, wrt_tag_o, wrt_data_o, TAG_FREE);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (wrt_en_o !== 1'b0 || wrt_tag_o !== TAG_FREE) begin
            n_err++; $display("FAIL rstmid_lost got en %b tag %h want 0 %h", wrt_en_o, wrt_tag_o, TAG_FREE);
        end
        @(negedge clk);
        rst = 1'b0; m_ptr = 0; sb.delete();
        apply(3'b001, ro, re, bo, be);
        n_vec++;
        if (bo.en_o !== 1'b1 || bo.tag_o !== 4'd6 || bo !== be) begin
            n_err++; $display("FAIL rstmid_rearb got %h want %h", bo, be);
        end
        apply(3'b000, ro, re, bo, be);
    endtask

    task automatic test_protocol_drop();
        int v0;
        do_reset();
        v0 = viol;
        t[0] = 4'h1; t[1] = 4'h2; t[2] = 4'hC;
        d[0] = 32'h1; d[1] = 32'h2; d[2] = 32'hC;
        apply(3'b111, ro, re, bo, be);
        n_vec++;
        if (ro !== 3'b011) begin n_err++; $display("FAIL drop_c1 got %b want 011", ro); end
        t[0] = 4'h3; t[1] = 4'h4;
        apply(3'b011, ro, re, bo, be);
        n_vec++;
        if (viol != v0 + 1) begin
            n_err++; $display("FAIL drop_monitor got %0d violations want %0d", viol - v0, 1);
        end
        n_vec++;
        if (bo.tag_o === 4'hC || bo.tag_t === 4'hC || bo !== be) begin
            n_err++; $display("FAIL drop_no_bcast got %h want %h", bo, be);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] held;
        do_reset();
        held = '0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!held[i] && $urandom_range(0, 2) != 0) begin
                    held[i] = 1'b1;
                    t[i] = TW'($urandom_range(0, 14));
                    d[i] = $urandom;
                end
            end
            apply(held, ro, re, bo, be);
            n_vec++;
            if (ro !== re) begin n_err++; $display("FAIL b2b_ready c%0d got %b want %b", c, ro, re); end
            n_vec++;
            if (bo !== be) begin n_err++; $display("FAIL b2b_bcast c%0d got %h want %h", c, bo, be); end
            held = held & ~re;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin t[i] = '0; d[i] = '0; end
        ro = '0; re = '0; bo = '0; be = '0;
        test_reset();
        test_single();
        test_pair();
        test_all_three();
        test_starvation();
        test_tag_free();
        test_reset_mid();
        test_back_to_back();
        test_protocol_drop();
        do_reset();
        n_vec++;
        if (viol != 1) begin n_err++; $display("FAIL total_violations got %0d want 1", viol); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
